// File: rtl/id_token_collector.sv
// Identifier token collector: measures and numbers identifiers flagged by the
// upstream recognizer and queues {index, length} records for a valid/ready consumer.
module id_token_collector #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       char,
    input  logic             char_valid,
    input  logic             match,
    input  logic             flush,
    output logic             tok_valid,
    input  logic             tok_ready,
    output logic [IDX_W-1:0] tok_idx,
    output logic [7:0]       tok_len,
    output logic [15:0]      tok_total,
    output logic             overflow
);

    localparam int unsigned LEN_W = 8;
    localparam int unsigned TOT_W = 16;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [LEN_W-1:0] len;
    } tok_rec_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_MATCH = 1'b1
    } state_t;

    function automatic logic f_alnum(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) ||
               ((c >= 8'h41) && (c <= 8'h5A)) ||
               ((c >= 8'h61) && (c <= 8'h7A));
    endfunction

    state_t           r_state;
    state_t           w_state_nxt;
    logic [LEN_W-1:0] r_run_len;
    logic [LEN_W-1:0] w_run_len_nxt;
    logic [LEN_W-1:0] w_run_inc;
    logic [LEN_W-1:0] r_last_len;
    logic [LEN_W-1:0] w_last_len_nxt;
    logic [IDX_W-1:0] r_next_idx;
    logic [TOT_W-1:0] r_total;
    logic             r_overflow;
    logic             w_emit;

    tok_rec_t         r_mem [DEPTH];
    tok_rec_t         w_rec;
    tok_rec_t         r_head;
    tok_rec_t         w_head_nxt;
    logic             r_tok_valid;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;
    logic             w_drop;

    assign w_run_inc = (r_run_len == 8'hFF) ? 8'hFF : r_run_len + 8'd1;

    // Token tracker: next state, run/last length updates and emit decision.
    always_comb begin
        w_state_nxt    = r_state;
        w_run_len_nxt  = r_run_len;
        w_last_len_nxt = r_last_len;
        w_emit         = 1'b0;

        if (char_valid) begin
            w_run_len_nxt = f_alnum(char) ? w_run_inc : '0;
        end
        if (flush) begin
            w_run_len_nxt = '0;
        end
        if (char_valid && match) begin
            w_last_len_nxt = w_run_inc;
        end

        case (r_state)
            S_IDLE: begin
                if (char_valid && match) begin
                    // A match char arriving with flush is opened and closed at once.
                    if (flush) begin
                        w_emit = 1'b1;
                    end else begin
                        w_state_nxt = S_MATCH;
                    end
                end
            end
            S_MATCH: begin
                if (flush || (char_valid && !match)) begin
                    w_emit      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_rec.idx = r_next_idx;
        w_rec.len = w_last_len_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Length tracking, token numbering and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run_len  <= '0;
            r_last_len <= '0;
            r_next_idx <= '0;
            r_total    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_run_len  <= w_run_len_nxt;
            r_last_len <= w_last_len_nxt;
            if (w_emit) begin
                r_next_idx <= r_next_idx + IDX_W'(1);
                if (r_total != 16'hFFFF) begin
                    r_total <= r_total + 16'd1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO control; the head register is preloaded with the post-edge head record.
    always_comb begin
        w_full      = (r_count == CNT_W'(DEPTH));
        w_pop       = r_tok_valid & tok_ready;
        w_push_ok   = w_emit & (~w_full | w_pop);
        w_drop      = w_emit & w_full & ~w_pop;
        w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
        w_rd_nxt    = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
        w_head_nxt  = r_head;
        if (w_count_nxt != '0) begin
            w_head_nxt = (w_push_ok && (r_wr_ptr == w_rd_nxt)) ? w_rec : r_mem[w_rd_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_tok_valid <= 1'b0;
            r_head      <= '0;
        end else begin
            r_rd_ptr    <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_tok_valid <= (w_count_nxt != '0);
            r_head      <= w_head_nxt;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
        end
    end

    assign tok_valid = r_tok_valid;
    assign tok_idx   = r_head.idx;
    assign tok_len   = r_head.len;
    assign tok_total = r_total;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_id_token_collector.sv
// Scoreboard bench for id_token_collector: expected records are queued as tokens
// are driven and compared as the consumer pops them.
module tb_id_token_collector;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  char;
    logic        char_valid;
    logic        match;
    logic        flush;
    logic        tok_valid;
    logic        tok_ready;
    logic [7:0]  tok_idx;
    logic [7:0]  tok_len;
    logic [15:0] tok_total;
    logic        overflow;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] sb [$];
    logic [7:0]  exp_idx;
    int          exp_total;
    logic        exp_ovf;

    id_token_collector #(.DEPTH(DEPTH), .IDX_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char       (char),
        .char_valid (char_valid),
        .match      (match),
        .flush      (flush),
        .tok_valid  (tok_valid),
        .tok_ready  (tok_ready),
        .tok_idx    (tok_idx),
        .tok_len    (tok_len),
        .tok_total  (tok_total),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stream input, then inputs return to idle.
    task automatic cyc(input logic [7:0] c, input logic v, input logic m, input logic f);
        char = c; char_valid = v; match = m; flush = f;
        step();
        char_valid = 1'b0; match = 1'b0; flush = 1'b0;
    endtask

    // Model of the emit side: index and total always advance; full FIFO drops.
    task automatic model_emit(input logic [7:0] len);
        if (sb.size() < DEPTH) sb.push_back({exp_idx, len});
        else exp_ovf = 1'b1;
        exp_idx   = exp_idx + 8'd1;
        exp_total = exp_total + 1;
    endtask

    task automatic model_reset();
        sb.delete();
        exp_idx = 8'd0; exp_total = 0; exp_ovf = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        model_reset();
    endtask

    // Token of n 'a' chars with match on the last one, closed by a space.
    task automatic send_token(input int n);
        for (int i = 0; i < n; i++) cyc(8'h61, 1'b1, (i == n - 1), 1'b0);
        cyc(8'h20, 1'b1, 1'b0, 1'b0);
        model_emit(8'(n));
    endtask

    task automatic pop_one(output logic v, output logic [15:0] rec);
        v = tok_valid; rec = {tok_idx, tok_len};
        tok_ready = 1'b1;
        step();
        tok_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; char = 8'h00; char_valid = 1'b0; match = 1'b0; flush = 1'b0; tok_ready = 1'b0;
        model_reset();
        step(); step();
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", tok_valid); end
        checks++; if (tok_idx !== 8'd0 || tok_len !== 8'd0) begin errors++; $display("FAIL reset_head got=%0d/%0d exp=0/0", tok_idx, tok_len); end
        checks++; if (tok_total !== 16'd0 || overflow !== 1'b0) begin errors++; $display("FAIL reset_stats got=%0d/%0b exp=0/0", tok_total, overflow); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        cyc("a", 1'b1, 1'b0, 1'b0);
        cyc("b", 1'b1, 1'b0, 1'b0);
        cyc("1", 1'b1, 1'b1, 1'b0);
        cyc("2", 1'b1, 1'b1, 1'b0);
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL basic_early got=%0b exp=0", tok_valid); end
        cyc("%", 1'b1, 1'b0, 1'b0);
        model_emit(8'd4);
        checks++; if (tok_valid !== 1'b1 || {tok_idx, tok_len} !== sb[0]) begin
            errors++; $display("FAIL basic_head got=%0b/%0d/%0d exp=1/%0d/%0d", tok_valid, tok_idx, tok_len, sb[0][15:8], sb[0][7:0]);
        end
        checks++; if (tok_total !== 16'(exp_total)) begin errors++; $display("FAIL basic_total got=%0d exp=%0d", tok_total, exp_total); end
    endtask

    task automatic test_index_flush();
        logic v; logic [15:0] rec, exp;
        cyc("f", 1'b1, 1'b0, 1'b0);
        cyc("g", 1'b1, 1'b0, 1'b0);
        cyc("o", 1'b1, 1'b0, 1'b0);
        cyc("2", 1'b1, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        model_emit(8'd4);
        checks++; if (tok_total !== 16'(exp_total)) begin errors++; $display("FAIL flush_total got=%0d exp=%0d", tok_total, exp_total); end
        for (int k = 0; k < 2; k++) begin
            exp = sb.pop_front();
            pop_one(v, rec);
            checks++; if (v !== 1'b1 || rec !== exp) begin errors++; $display("FAIL flush_pop%0d got=%0b/%h exp=1/%h", k, v, rec, exp); end
        end
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL flush_empty got=%0b exp=0", tok_valid); end
    endtask

    task automatic test_flush_edges();
        logic v; logic [15:0] rec, exp;
        cyc("q", 1'b1, 1'b0, 1'b0);
        cyc("r", 1'b1, 1'b1, 1'b0);
        cyc("s", 1'b1, 1'b1, 1'b1);
        model_emit(8'd3);
        cyc("a", 1'b1, 1'b0, 1'b0);
        cyc("b", 1'b1, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0, 1'b1);
        cyc("c", 1'b1, 1'b1, 1'b0);
        cyc(".", 1'b1, 1'b0, 1'b0);
        model_emit(8'd1);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            pop_one(v, rec);
            checks++; if (v !== 1'b1 || rec !== exp) begin errors++; $display("FAIL fedge_pop got=%0b/%h exp=1/%h", v, rec, exp); end
        end
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL fedge_empty got=%0b exp=0", tok_valid); end
    endtask

    task automatic test_overflow();
        logic v; logic [15:0] rec, exp;
        apply_reset();
        for (int t = 0; t < 5; t++) send_token(t + 1);
        checks++; if (tok_valid !== 1'b1 || {tok_idx, tok_len} !== sb[0]) begin
            errors++; $display("FAIL ovf_head got=%0b/%0d/%0d exp=1/%0d/%0d", tok_valid, tok_idx, tok_len, sb[0][15:8], sb[0][7:0]);
        end
        checks++; if (overflow !== exp_ovf) begin errors++; $display("FAIL ovf_flag got=%0b exp=%0b", overflow, exp_ovf); end
        checks++; if (tok_total !== 16'(exp_total)) begin errors++; $display("FAIL ovf_total got=%0d exp=%0d", tok_total, exp_total); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            pop_one(v, rec);
            checks++; if (v !== 1'b1 || rec !== exp) begin errors++; $display("FAIL ovf_drain got=%0b/%h exp=1/%h", v, rec, exp); end
        end
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL ovf_gap got=%0b exp=0 (dropped idx must be absent)", tok_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic v; logic [15:0] rec, exp;
        apply_reset();
        for (int t = 0; t < 4; t++) send_token(t + 2);
        cyc("a", 1'b1, 1'b0, 1'b0);
        cyc("b", 1'b1, 1'b1, 1'b0);
        exp = sb.pop_front();
        checks++; if (tok_valid !== 1'b1 || {tok_idx, tok_len} !== exp) begin
            errors++; $display("FAIL fpp_head got=%0b/%h exp=1/%h", tok_valid, {tok_idx, tok_len}, exp);
        end
        tok_ready = 1'b1;
        cyc(" ", 1'b1, 1'b0, 1'b0);
        tok_ready = 1'b0;
        model_emit(8'd2);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got=%0b exp=0", overflow); end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            pop_one(v, rec);
            checks++; if (v !== 1'b1 || rec !== exp) begin errors++; $display("FAIL fpp_drain got=%0b/%h exp=1/%h", v, rec, exp); end
        end
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got=%0b exp=0", tok_valid); end
    endtask

    task automatic test_saturation();
        logic v; logic [15:0] rec, exp;
        for (int i = 0; i < 300; i++) begin
            if (i == 100) begin
                for (int g = 0; g < 3; g++) cyc(".", 1'b0, 1'b0, 1'b0);
            end
            cyc(8'(8'h61 + (i % 26)), 1'b1, (i != 0), 1'b0);
        end
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL sat_early got=%0b exp=0", tok_valid); end
        cyc(".", 1'b1, 1'b0, 1'b0);
        model_emit(8'd255);
        cyc("a", 1'b1, 1'b0, 1'b0);
        cyc("b", 1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) cyc("%", 1'b0, 1'b0, 1'b0);
        cyc("c", 1'b1, 1'b1, 1'b0);
        cyc(".", 1'b1, 1'b0, 1'b0);
        model_emit(8'd3);
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            pop_one(v, rec);
            checks++; if (v !== 1'b1 || rec !== exp) begin errors++; $display("FAIL sat_pop got=%0b/%h exp=1/%h", v, rec, exp); end
        end
        checks++; if (tok_total !== 16'(exp_total)) begin errors++; $display("FAIL sat_total got=%0d exp=%0d", tok_total, exp_total); end
    endtask

    task automatic test_async_reset();
        logic v; logic [15:0] rec, exp;
        send_token(2);
        send_token(3);
        cyc("a", 1'b1, 1'b0, 1'b0);
        cyc("b", 1'b1, 1'b1, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checks++; if (tok_valid !== 1'b0 || tok_total !== 16'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL arst_immediate got=%0b/%0d/%0b exp=0/0/0", tok_valid, tok_total, overflow);
        end
        model_reset();
        step(); step();
        rst_n = 1'b1;
        step();
        cyc(" ", 1'b1, 1'b0, 1'b0);
        checks++; if (tok_valid !== 1'b0) begin errors++; $display("FAIL arst_discard got=%0b exp=0", tok_valid); end
        send_token(1);
        exp = sb.pop_front();
        pop_one(v, rec);
        checks++; if (v !== 1'b1 || rec !== exp) begin errors++; $display("FAIL arst_first got=%0b/%h exp=1/%h", v, rec, exp); end
        checks++; if (tok_total !== 16'(exp_total) || tok_valid !== 1'b0) begin
            errors++; $display("FAIL arst_after got=%0d/%0b exp=%0d/0", tok_total, tok_valid, exp_total);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_index_flush();
        test_flush_edges();
        test_overflow();
        test_full_push_pop();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
